// File: rtl/align_stage.sv
// align_stage: registers one FPU operation per input handshake, sorts the
// operands by in_exchange and right-aligns sorted operand B's fraction with
// guard/round/sticky capture. Valid/ready interface with a one-entry skid
// buffer so in_ready depends only on registered state.
module align_stage #(
  parameter int FRAC_W  = 24,
  parameter int EXP_W   = 8,
  parameter int SHIFT_W = 5
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [2:0]          in_op,
  input  logic                in_sign_a,
  input  logic                in_sign_b,
  input  logic [EXP_W-1:0]    in_exponent_a,
  input  logic [EXP_W-1:0]    in_exponent_b,
  input  logic [FRAC_W-1:0]   in_fraction_a,
  input  logic [FRAC_W-1:0]   in_fraction_b,
  input  logic [2:0]          in_type_a,
  input  logic [2:0]          in_type_b,
  input  logic                in_exchange,
  input  logic [SHIFT_W-1:0]  in_shift,
  input  logic                in_post_sign,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [2:0]          out_op,
  output logic                out_sign,
  output logic [EXP_W-1:0]    out_exponent_a,
  output logic [EXP_W-1:0]    out_exponent_b,
  output logic [FRAC_W+2:0]   out_fraction_a,
  output logic [FRAC_W+2:0]   out_fraction_b,
  output logic [2:0]          out_type_a,
  output logic [2:0]          out_type_b
);

  localparam int EXT_W = FRAC_W + 3;

  typedef struct packed {
    logic [2:0]       op;
    logic             sign;
    logic [EXP_W-1:0] exp_a;
    logic [EXP_W-1:0] exp_b;
    logic [EXT_W-1:0] frac_a;
    logic [EXT_W-1:0] frac_b;
    logic [2:0]       type_a;
    logic [2:0]       type_b;
  } stage_t;

  stage_t           in_word;
  stage_t           out_word;
  stage_t           skid_word;
  logic             skid_valid;
  logic [FRAC_W-1:0] sorted_frac_b;
  logic [EXT_W-1:0] ext_b;
  logic [EXT_W-1:0] shifted_b;
  logic [EXT_W-1:0] kept_b;
  logic             lost_b;
  logic             in_fire;

  // Operand signs swap with the rest of the operand, but only the
  // control-supplied post_sign leaves this stage.
  logic sign_unused;
  assign sign_unused = in_sign_a ^ in_sign_b;

  assign in_ready = ~skid_valid;
  assign in_fire  = in_valid & in_ready;

  // Sort operands and align B; sticky collects every bit shifted past bit 0,
  // found by shifting back and comparing against the unshifted value.
  always_comb begin
    in_word       = '0;
    sorted_frac_b = in_exchange ? in_fraction_a : in_fraction_b;
    ext_b         = {sorted_frac_b, 3'b000};
    shifted_b     = ext_b >> in_shift;
    kept_b        = shifted_b << in_shift;
    lost_b        = |(ext_b & ~kept_b);

    in_word.op     = in_op;
    in_word.sign   = in_post_sign;
    in_word.exp_a  = in_exchange ? in_exponent_b : in_exponent_a;
    in_word.exp_b  = in_exchange ? in_exponent_a : in_exponent_b;
    in_word.frac_a = {(in_exchange ? in_fraction_b : in_fraction_a), 3'b000};
    in_word.frac_b = {shifted_b[EXT_W-1:1], shifted_b[0] | lost_b};
    in_word.type_a = in_exchange ? in_type_b : in_type_a;
    in_word.type_b = in_exchange ? in_type_a : in_type_b;
  end

  // Output register and skid buffer: the output reloads whenever it is empty
  // or being consumed, preferring the older skidded op; a new op arriving
  // while the output is stalled parks in the skid slot.
  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid  <= 1'b0;
      skid_valid <= 1'b0;
      out_word   <= '0;
      skid_word  <= '0;
    end else if (~out_valid | out_ready) begin
      if (skid_valid) begin
        out_word   <= skid_word;
        out_valid  <= 1'b1;
        skid_valid <= 1'b0;
      end else if (in_fire) begin
        out_word  <= in_word;
        out_valid <= 1'b1;
      end else begin
        out_valid <= 1'b0;
      end
    end else if (in_fire) begin
      skid_word  <= in_word;
      skid_valid <= 1'b1;
    end
  end

  assign out_op         = out_word.op;
  assign out_sign       = out_word.sign;
  assign out_exponent_a = out_word.exp_a;
  assign out_exponent_b = out_word.exp_b;
  assign out_fraction_a = out_word.frac_a;
  assign out_fraction_b = out_word.frac_b;
  assign out_type_a     = out_word.type_a;
  assign out_type_b     = out_word.type_b;

endmodule
